// File: rtl/uart_byte_tx_pkg.sv
// uart_byte_tx_pkg: transmitter state encoding, default bit period and MIN framing bytes
package uart_byte_tx_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;
  localparam int CLKS_PER_BIT_DEF = 104;
  localparam logic [7:0] MIN_SOF   = 8'hAA;
  localparam logic [7:0] MIN_STUFF = 8'h55;
  localparam logic [7:0] MIN_EOF   = 8'h55;
endpackage

// File: rtl/uart_byte_tx_baud.sv
// baud_tick_gen: bit-period counter with a one-cycle tick at every bit boundary
module baud_tick_gen
  import uart_byte_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int W = $clog2(CLKS_PER_BIT);
  logic [W-1:0] cnt;
  assign tick = en && cnt == W'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk) begin
    if (rst || clr || tick) cnt <= '0;
    else if (en) cnt <= cnt + W'(1);
  end
endmodule

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: 8N1/8N2 LSB-first UART transmitter with a valid/ready byte input
module uart_byte_tx
  import uart_byte_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int STOP_BITS    = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_tx,
  output logic       o_busy
);
  state_t     state, nxt;
  logic [7:0] sh;
  logic [2:0] bit_cnt;
  logic       tick, accept, last_bit, last_stop, tx_nxt;
  assign accept    = state == IDLE && i_valid && !i_rst;
  assign last_bit  = bit_cnt == 3'd7;
  assign last_stop = bit_cnt == 3'(STOP_BITS - 1);
  baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk (i_clk),
    .rst (i_rst),
    .clr (accept),
    .en  (state != IDLE),
    .tick(tick)
  );
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      o_tx    <= 1'b1;
      sh      <= '0;
      bit_cnt <= '0;
    end else begin
      state <= nxt;
      o_tx  <= tx_nxt;
      if (accept) sh <= i_data;
      else if (state == DATA && tick) sh <= sh >> 1;
      // bit_cnt counts data bits in DATA and stop bits in STOP, zeroed on each state exit
      if (tick && state != START) bit_cnt <= nxt == state ? bit_cnt + 3'd1 : 3'd0;
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = accept ? START : IDLE;
      START:   nxt = tick ? DATA : START;
      DATA:    nxt = tick && last_bit ? STOP : DATA;
      default: nxt = tick && last_stop ? IDLE : STOP;
    endcase
  end
  always_comb begin
    o_ready = state == IDLE && !i_rst;
    o_busy  = state != IDLE;
    tx_nxt  = o_tx;
    case (state)
      IDLE:    tx_nxt = !accept;
      START:   tx_nxt = tick ? sh[0] : 1'b0;
      DATA:    tx_nxt = tick ? (last_bit ? 1'b1 : sh[1]) : o_tx;
      default: tx_nxt = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_uart_byte_tx.sv
// tb_uart_byte_tx: randomized frame checks of two transmitter configurations against a waveform model
module tb_uart_byte_tx;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = 8'h00;
  logic [1:0] valid = 2'b00;
  logic [1:0] ready, tx, busy;
  int n_vec = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  uart_byte_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid[0]),
    .o_ready(ready[0]), .o_tx(tx[0]), .o_busy(busy[0])
  );
  uart_byte_tx #(.CLKS_PER_BIT(2), .STOP_BITS(2)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_data(data), .i_valid(valid[1]),
    .o_ready(ready[1]), .o_tx(tx[1]), .o_busy(busy[1])
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic chk_idle(input int d, input logic rdy);
    chk("idle_tx", tx[d], 1'b1);
    chk("idle_busy", busy[d], 1'b0);
    chk("idle_ready", ready[d], rdy);
  endtask
  // mode 0: plain, 1: random i_data/i_valid noise during the frame, 2: keep offering the byte
  task automatic send(input int d, input logic [7:0] b, input int mode);
    int cpb, s, len;
    logic e;
    cpb = d ? 2 : 4;
    s   = d ? 2 : 1;
    len = (9 + s) * cpb;
    data = b;
    valid[d] = 1'b1;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      e = k < cpb ? 1'b0 : k < 9 * cpb ? b[(k - cpb) / cpb] : 1'b1;
      chk($sformatf("tx[%0d] byte %02h cyc %0d", d, b, k), tx[d], e);
      chk("busy", busy[d], 1'b1);
      chk("ready", ready[d], 1'b0);
      if (mode == 1) begin
        valid[d] = 1'($urandom);
        data = 8'($urandom);
      end else if (mode == 0) valid[d] = 1'b0;
    end
    @(negedge clk);
    chk_idle(d, 1'b1);
    if (mode != 2) valid[d] = 1'b0;
  endtask
  initial begin
    valid = 2'b11;
    data = 8'h5A;
    repeat (3) begin
      @(negedge clk);
      chk_idle(0, 1'b0);
      chk_idle(1, 1'b0);
    end
    rst = 1'b0;
    valid = 2'b00;
    repeat (3) begin
      @(negedge clk);
      chk_idle(0, 1'b1);
      chk_idle(1, 1'b1);
    end
    send(0, 8'hA5, 0);
    send(0, 8'h01, 2);
    send(0, 8'hFF, 0);
    send(0, 8'h3C, 1);
    send(1, 8'hFF, 0);
    data = 8'h00;
    valid[0] = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      chk("abort_frame_tx", tx[0], 1'b0);
      valid[0] = 1'b0;
    end
    rst = 1'b1;
    valid[0] = 1'b1;
    @(negedge clk);
    chk_idle(0, 1'b0);
    rst = 1'b0;
    valid[0] = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk_idle(0, 1'b1);
    end
    send(0, 8'h55, 0);
    repeat (12) begin
      int d;
      d = $urandom_range(0, 1);
      send(d, 8'($urandom), $urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        chk_idle(d, 1'b1);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_byte_tx.md
UART_BYTE_TX -- requirements
Module: uart_byte_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 104, SHALL set the number of i_clk cycles per serial bit (12 MHz / 115200 baud); legal range 2..65535.
REQ-002 Parameter STOP_BITS, default 1, SHALL set the number of stop bits per frame; legal values 1 or 2.
REQ-003 i_clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 i_rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 i_data  input  8  SHALL carry the byte to send (MIN transmit FSM o_data); sampled only on accept.
REQ-006 i_valid  input  1  SHALL indicate i_data holds a byte to send (MIN transmit FSM o_istx).
REQ-007 o_ready  output  1  SHALL be high when a byte offered on i_valid will be accepted this cycle.
REQ-008 o_tx  output  1  SHALL be the serial line, idle high, 8N1 (or 8N2) LSB first.
REQ-009 o_busy  output  1  SHALL be high whenever a frame is in progress, i.e. state is not IDLE.

Function
REQ-010 The state machine SHALL have states IDLE, START, DATA and STOP, encoded in 2 bits.
REQ-011 In IDLE, o_ready SHALL be 1 and o_tx SHALL be 1.
REQ-012 An accept SHALL occur when i_valid=1 and o_ready=1 on a rising edge; i_data SHALL then be latched into an 8-bit shift register, and the state SHALL go to START.
REQ-013 o_tx SHALL be registered: o_tx=0 beginning the cycle after the accept, held for exactly CLKS_PER_BIT cycles.
REQ-014 DATA SHALL drive shift-register bit 0 onto o_tx for CLKS_PER_BIT cycles, shift right, and repeat for exactly 8 bits, counted by a 3-bit bit counter.
REQ-015 STOP SHALL drive o_tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then return to IDLE.
REQ-016 Total frame length from the first start-bit cycle to the return to IDLE SHALL be (9+STOP_BITS)*CLKS_PER_BIT cycles.
REQ-017 o_ready SHALL be 0 in START, DATA and STOP; i_valid in those states SHALL be ignored, and i_data changes SHALL not affect the frame in flight.
REQ-018 Back-to-back bytes: a byte held on i_valid SHALL be accepted in the first IDLE cycle, so frames are separated by exactly one idle-high cycle.
REQ-019 The baud counter SHALL be ceil(log2(CLKS_PER_BIT)) bits wide, count 0..CLKS_PER_BIT-1, and reload to 0 on every bit boundary and on accept; it SHALL never wrap mid-bit.
REQ-020 i_valid=0 in IDLE SHALL keep the block in IDLE indefinitely with no counter activity.

Reset
REQ-021 While i_rst=1 at a clock edge: state becomes IDLE, o_tx=1, o_busy=0, counters and shift register clear to 0.
REQ-022 o_ready SHALL be 0 in any cycle where i_rst=1, and 1 from the first cycle after release.
REQ-023 Reset mid-frame SHALL abort the frame, with o_tx=1 from the next edge; the aborted byte SHALL not be resent.
REQ-024 An i_valid asserted during reset SHALL not be accepted.

Structure
REQ-025 State encodings and the default CLKS_PER_BIT SHALL live in the shared MIN defines header alongside the MIN framing constants.
REQ-026 The bit-period counter SHALL be a sub-module, baud_tick_gen, producing a one-cycle tick at each bit boundary, with a synchronous clear input.
REQ-027 The block SHALL contain no combinational path from i_data to o_tx.

Verification (CLKS_PER_BIT=4, STOP_BITS=1 unless stated)
REQ-028 Send 0xA5 from idle -> o_tx low for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then high for 4 cycles; 40 cycles total; o_busy high for exactly those 40 cycles.
REQ-029 Hold i_valid high with 0x01 then 0xFF -> second start bit begins exactly 1 cycle after the first frame's stop bit ends; o_ready high for exactly 1 cycle between frames.
REQ-030 Change i_data and pulse i_valid during DATA of 0x3C -> line waveform equals the 0x3C frame and o_ready stays 0.
REQ-031 Assert i_rst for 1 cycle at cycle 15 of a 0x00 frame -> o_tx=1 from the next edge, o_ready=1 one cycle after release, and a new 0x55 frame is correct.
REQ-032 STOP_BITS=2, CLKS_PER_BIT=2, send 0xFF -> 22-cycle frame, with 2 start cycles low and 20 cycles high.
REQ-033 Connect to min_transmit_fsm with N_DATA_BYTE=2 and id 0x01 -> the decoded UART byte stream matches the MIN frame byte sequence, with no bytes lost or duplicated.
